// File: rtl/fod_spi_slave.sv
// rtl/fod_spi_slave.sv - SPI mode-0 responder driving the FOD control register file
//
// Purpose: oversamples SCK/CSN/MOSI on CLK, decodes 24-bit frames
//          ({RW, ADDR[6:0], DATA[15:0]}, MSB first) and holds every FOD
//          digital-controller control field in CLK-domain registers.
// Ports:
//   CLK, NRST                 system clock, synchronous active-low reset
//   SCK, CSN, MOSI            SPI pins (asynchronous, oversampled)
//   MISO, MISO_OE             serial read data and its output enable
//   REG_WR, REG_ADDR          one-cycle commit strobe and last written address
//   FCW_FOD .. KDTCD_INIT     control fields decoded from the register map
module fod_spi_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] ID_VALUE    = 16'hF0D1,
    parameter logic [21:0] FCW_RST     = 22'h04C000
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        SCK,
    input  logic        CSN,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    output logic        REG_WR,
    output logic [6:0]  REG_ADDR,
    output logic [21:0] FCW_FOD,
    output logic        PCALI_EN,
    output logic        FREQ_C_EN,
    output logic        FREQ_C_MODE,
    output logic        RT_EN,
    output logic        DTCCALI_EN,
    output logic        OFSTCALI_EN,
    output logic        SYS_EN,
    output logic        DSM_SYNC_NRST_EN,
    output logic        NCO_SYNC_NRST_EN,
    output logic        FREQ_HOP,
    output logic [4:0]  FREQ_C_KS,
    output logic [4:0]  PCALI_KS,
    output logic [4:0]  KB,
    output logic [4:0]  KC,
    output logic [4:0]  KD,
    output logic [2:0]  PCALI_FREQDOWN,
    output logic [1:0]  PSEG,
    output logic [1:0]  CALIORDER,
    output logic [9:0]  PHASE_CTRL,
    output logic [9:0]  KDTCB_INIT,
    output logic [9:0]  KDTCC_INIT,
    output logic [9:0]  KDTCD_INIT
);

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_CMD       = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Pin synchronisers plus one history flop for edge detection
    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_prev_q, csn_prev_q;
    logic                   sck_s, csn_s, mosi_s, sck_rise, sck_fall, csn_fall;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], CSN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;

    // Frame engine
    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [14:0] rx_q, rx_d;
    logic        rw_q, rw_d;
    logic [15:0] tx_q, tx_d;
    logic        oe_q, oe_d;
    logic        pend_q, pend_d;
    logic [6:0]  pend_addr_q, pend_addr_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;

    // Register file
    logic [13:0] ctrl_q;
    logic [15:0] stage_q;
    logic [21:0] fcw_q;
    logic [12:0] r3_q;
    logic [9:0]  phase_q;
    logic [14:0] k_q;
    logic [9:0]  kdtcb_q, kdtcc_q, kdtcd_q;
    logic        reg_wr_q;
    logic [6:0]  reg_addr_q;

    // Address of the command byte as it completes on the 8th rising edge
    assign rd_addr = {rx_q[5:0], mosi_s};

    always_comb begin
        rd_data = 16'h0000;
        case (rd_addr)
            7'h00: rd_data = {2'b00, ctrl_q};
            7'h01: rd_data = fcw_q[15:0];
            7'h02: rd_data = {10'h000, fcw_q[21:16]};
            7'h03: rd_data = {3'b000, r3_q};
            7'h04: rd_data = {6'h00, phase_q};
            7'h05: rd_data = {1'b0, k_q};
            7'h06: rd_data = {6'h00, kdtcb_q};
            7'h07: rd_data = {6'h00, kdtcc_q};
            7'h08: rd_data = {6'h00, kdtcd_q};
            7'h7F: rd_data = ID_VALUE;
            default: rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        tx_d        = tx_q;
        oe_d        = oe_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        case (state_q)
            ST_WAIT_IDLE: if (csn_s) state_d = ST_IDLE;
            // CSN falling wins over a coincident SCK edge: only CSN is looked at here
            ST_IDLE: if (csn_fall) begin
                state_d = ST_CMD;
                cnt_d   = 5'd0;
            end
            ST_CMD, ST_DATA: begin
                if (csn_s) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end else begin
                    // The falling edge right after the command byte must keep
                    // bit 15 on MISO for the master's 9th rising edge.
                    if (sck_fall && state_q == ST_DATA && rw_q && cnt_q > 5'd8)
                        tx_d = {tx_q[14:0], 1'b0};
                    if (sck_rise) begin
                        rx_d  = {rx_q[13:0], mosi_s};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            rw_d    = rx_q[6];
                            state_d = ST_DATA;
                            if (rx_q[6]) begin
                                tx_d = rd_data;
                                oe_d = 1'b1;
                            end
                            pend_addr_d = rd_addr;
                        end else if (cnt_q == 5'd23) begin
                            state_d = ST_DONE;
                            if (!rw_q) begin
                                pend_d      = 1'b1;
                                pend_data_d = {rx_q[14:0], mosi_s};
                            end
                        end
                    end
                end
            end
            ST_DONE: if (csn_s) begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= 5'd0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            tx_q        <= '0;
            oe_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            tx_q        <= tx_d;
            oe_q        <= oe_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Commit one CLK after the 24th rising edge; REG_WR/REG_ADDR move together
    // with the register, and undefined / read-only addresses still strobe.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            ctrl_q     <= 14'h3036;
            stage_q    <= 16'h0000;
            fcw_q      <= FCW_RST;
            r3_q       <= {3'd0, 5'd8, 5'd0};
            phase_q    <= 10'd0;
            k_q        <= {5'h1B, 5'h1D, 5'h00};
            kdtcb_q    <= 10'd390;
            kdtcc_q    <= 10'd195;
            kdtcd_q    <= 10'd0;
            reg_wr_q   <= 1'b0;
            reg_addr_q <= 7'h00;
        end else begin
            reg_wr_q <= pend_q;
            if (pend_q) begin
                reg_addr_q <= pend_addr_q;
                case (pend_addr_q)
                    7'h00: ctrl_q  <= pend_data_q[13:0];
                    7'h01: stage_q <= pend_data_q;
                    7'h02: fcw_q   <= {pend_data_q[5:0], stage_q};
                    7'h03: r3_q    <= pend_data_q[12:0];
                    7'h04: phase_q <= pend_data_q[9:0];
                    7'h05: k_q     <= pend_data_q[14:0];
                    7'h06: kdtcb_q <= pend_data_q[9:0];
                    7'h07: kdtcc_q <= pend_data_q[9:0];
                    7'h08: kdtcd_q <= pend_data_q[9:0];
                    default: ;
                endcase
            end
        end
    end

    assign MISO             = oe_q & tx_q[15];
    assign MISO_OE          = oe_q;
    assign REG_WR           = reg_wr_q;
    assign REG_ADDR         = reg_addr_q;
    assign FCW_FOD          = fcw_q;
    assign SYS_EN           = ctrl_q[0];
    assign DSM_SYNC_NRST_EN = ctrl_q[1];
    assign NCO_SYNC_NRST_EN = ctrl_q[2];
    assign FREQ_HOP         = ctrl_q[3];
    assign RT_EN            = ctrl_q[4];
    assign PCALI_EN         = ctrl_q[5];
    assign FREQ_C_EN        = ctrl_q[6];
    assign FREQ_C_MODE      = ctrl_q[7];
    assign DTCCALI_EN       = ctrl_q[8];
    assign OFSTCALI_EN      = ctrl_q[9];
    assign PSEG             = ctrl_q[11:10];
    assign CALIORDER        = ctrl_q[13:12];
    assign FREQ_C_KS        = r3_q[4:0];
    assign PCALI_KS         = r3_q[9:5];
    assign PCALI_FREQDOWN   = r3_q[12:10];
    assign PHASE_CTRL       = phase_q;
    assign KB               = k_q[4:0];
    assign KC               = k_q[9:5];
    assign KD               = k_q[14:10];
    assign KDTCB_INIT       = kdtcb_q;
    assign KDTCC_INIT       = kdtcc_q;
    assign KDTCD_INIT       = kdtcd_q;

endmodule

// File: tb/tb_fod_spi_slave.sv
// tb/tb_fod_spi_slave.sv - randomized self-checking bench for fod_spi_slave
module tb_fod_spi_slave;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        SCK = 1'b0, CSN = 1'b1, MOSI = 1'b0;
    logic        MISO, MISO_OE, REG_WR;
    logic [6:0]  REG_ADDR;
    logic [21:0] FCW_FOD;
    logic        PCALI_EN, FREQ_C_EN, FREQ_C_MODE, RT_EN, DTCCALI_EN, OFSTCALI_EN;
    logic        SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP;
    logic [4:0]  FREQ_C_KS, PCALI_KS, KB, KC, KD;
    logic [2:0]  PCALI_FREQDOWN;
    logic [1:0]  PSEG, CALIORDER;
    logic [9:0]  PHASE_CTRL, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT;

    fod_spi_slave dut (
        .CLK(CLK), .NRST(NRST), .SCK(SCK), .CSN(CSN), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .REG_WR(REG_WR), .REG_ADDR(REG_ADDR),
        .FCW_FOD(FCW_FOD), .PCALI_EN(PCALI_EN), .FREQ_C_EN(FREQ_C_EN),
        .FREQ_C_MODE(FREQ_C_MODE), .RT_EN(RT_EN), .DTCCALI_EN(DTCCALI_EN),
        .OFSTCALI_EN(OFSTCALI_EN), .SYS_EN(SYS_EN),
        .DSM_SYNC_NRST_EN(DSM_SYNC_NRST_EN), .NCO_SYNC_NRST_EN(NCO_SYNC_NRST_EN),
        .FREQ_HOP(FREQ_HOP), .FREQ_C_KS(FREQ_C_KS), .PCALI_KS(PCALI_KS),
        .KB(KB), .KC(KC), .KD(KD), .PCALI_FREQDOWN(PCALI_FREQDOWN),
        .PSEG(PSEG), .CALIORDER(CALIORDER), .PHASE_CTRL(PHASE_CTRL),
        .KDTCB_INIT(KDTCB_INIT), .KDTCC_INIT(KDTCC_INIT), .KDTCD_INIT(KDTCD_INIT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic quiet = 1'b0;

    // Model: readback image per address, FCW staging word, last written address
    logic [15:0] mreg [0:8];
    logic [15:0] mstage;
    logic [6:0]  mlast;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] fmask(input logic [6:0] a);
        case (a)
            7'h00: return 16'h3FFF;
            7'h01: return 16'hFFFF;
            7'h02: return 16'h003F;
            7'h03: return 16'h1FFF;
            7'h05: return 16'h7FFF;
            default: return 16'h03FF;
        endcase
    endfunction

    task automatic model_reset();
        mreg[0] = 16'h3036; mreg[1] = 16'hC000; mreg[2] = 16'h0004;
        mreg[3] = 16'h0100; mreg[4] = 16'h0000; mreg[5] = 16'h6FA0;
        mreg[6] = 16'd390;  mreg[7] = 16'd195;  mreg[8] = 16'h0000;
        mstage = 16'h0000;  mlast = 7'h00;
    endtask

    function automatic logic [15:0] model_read(input logic [6:0] a);
        if (a == 7'h7F) return 16'hF0D1;
        if (a <= 7'h08) return mreg[a];
        return 16'h0000;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [15:0] d);
        if (a == 7'h01) mstage = d;
        else if (a == 7'h02) begin
            mreg[1] = mstage;
            mreg[2] = d & 16'h003F;
        end else if (a <= 7'h08) mreg[a] = d & fmask(a);
        mlast = a;
    endtask

    always @(negedge CLK) if (REG_WR === 1'b1) wr_cnt++;

    // Compare process: between frames every output must equal the model
    always @(negedge CLK) begin
        if (quiet) begin
            chk("ctrl", {CALIORDER, PSEG, OFSTCALI_EN, DTCCALI_EN, FREQ_C_MODE, FREQ_C_EN,
                         PCALI_EN, RT_EN, FREQ_HOP, NCO_SYNC_NRST_EN, DSM_SYNC_NRST_EN, SYS_EN},
                mreg[0][13:0]);
            chk("fcw_fod", FCW_FOD, {mreg[2][5:0], mreg[1]});
            chk("reg3", {PCALI_FREQDOWN, PCALI_KS, FREQ_C_KS}, mreg[3][12:0]);
            chk("phase_ctrl", PHASE_CTRL, mreg[4][9:0]);
            chk("k", {KD, KC, KB}, mreg[5][14:0]);
            chk("kdtcb", KDTCB_INIT, mreg[6][9:0]);
            chk("kdtcc", KDTCC_INIT, mreg[7][9:0]);
            chk("kdtcd", KDTCD_INIT, mreg[8][9:0]);
            chk("idle_pins", {MISO, MISO_OE, REG_WR}, 3'b000);
            chk("reg_addr", REG_ADDR, mlast);
        end
    end

    // Master: SCK half period of 5 CLK; MOSI changes and MISO is sampled while SCK is low
    task automatic frame(input logic rw, input logic [6:0] a, input logic [15:0] d,
                         input int nbits, input int rst_bit, output logic [15:0] rd);
        logic [23:0] w;
        w = {rw, a, d};
        rd = 16'h0000;
        quiet = 1'b0;
        @(negedge CLK);
        CSN = 1'b0;
        repeat (5) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                NRST = 1'b0;
                repeat (3) @(negedge CLK);
                NRST = 1'b1;
                model_reset();
            end
            MOSI = (i < 24) ? w[23-i] : 1'($urandom_range(1));
            repeat (5) @(negedge CLK);
            if (rw && i >= 8 && i < 24) rd[23-i] = MISO;
            if (rw && i == 8) chk("miso_oe_data", MISO_OE, 1'b1);
            SCK = 1'b1;
            repeat (5) @(negedge CLK);
            SCK = 1'b0;
        end
        repeat (5) @(negedge CLK);
        CSN = 1'b1;
        MOSI = 1'b0;
        repeat (12) @(negedge CLK);
        quiet = 1'b1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] d, input int nbits);
        int c0;
        logic [15:0] rd;
        c0 = wr_cnt;
        frame(1'b0, a, d, nbits, -1, rd);
        model_write(a, d);
        chk("wr_pulses", wr_cnt - c0, 1);
    endtask

    task automatic do_read(input logic [6:0] a, output logic [15:0] rd);
        int c0;
        c0 = wr_cnt;
        frame(1'b1, a, 16'h0000, 24, -1, rd);
        chk("read_data", rd, model_read(a));
        chk("rd_pulses", wr_cnt - c0, 0);
    endtask

    initial begin
        logic [15:0] rd;
        int c0, r, nb;
        logic rw;
        logic [6:0] a;
        logic [15:0] d;

        model_reset();
        repeat (5) @(negedge CLK);
        NRST = 1'b1;
        repeat (10) @(negedge CLK);
        quiet = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_kc", KC, 5'h1D);
        chk("rst_kdtcb", KDTCB_INIT, 10'd390);
        chk("rst_fcw", FCW_FOD, 22'h04C000);
        chk("rst_reg_addr", REG_ADDR, 7'h00);

        do_read(7'h00, rd); chk("read_ctrl_lit", rd, 16'h3036);
        do_read(7'h7F, rd); chk("read_id_lit", rd, 16'hF0D1);

        // FCW staging then atomic commit
        c0 = wr_cnt;
        do_write(7'h01, 16'h8000, 24);
        chk("fcw_after_lo", FCW_FOD, 22'h04C000);
        do_read(7'h01, rd); chk("read_fcw_lo_live", rd, 16'hC000);
        do_write(7'h02, 16'h0005, 24);
        chk("fcw_after_hi", FCW_FOD, 22'h058000);
        chk("fcw_pulses", wr_cnt - c0, 2);

        do_write(7'h05, 16'h7FFF, 24);
        chk("kb_kc_kd", {KB, KC, KD}, 15'h7FFF);
        do_read(7'h05, rd); chk("read_k_lit", rd, 16'h7FFF);

        // Aborted write after 20 bits
        c0 = wr_cnt;
        frame(1'b0, 7'h04, 16'h03FF, 20, -1, rd);
        chk("abort_pulses", wr_cnt - c0, 0);
        chk("abort_phase", PHASE_CTRL, 10'd0);

        // Over-long frame
        do_write(7'h00, 16'h0001, 30);
        chk("long_sys_en", SYS_EN, 1'b1);
        do_read(7'h00, rd);

        // Reset in the middle of a write frame
        c0 = wr_cnt;
        frame(1'b0, 7'h04, 16'h0155, 24, 12, rd);
        chk("midrst_pulses", wr_cnt - c0, 0);
        chk("midrst_phase", PHASE_CTRL, 10'd0);
        do_write(7'h04, 16'h0155, 24);
        chk("post_rst_phase", PHASE_CTRL, 10'h155);

        // Randomized traffic
        for (int n = 0; n < 50; n++) begin
            rw = 1'($urandom_range(1));
            r = $urandom_range(11);
            if (r < 9) a = 7'(r);
            else if (r == 9) a = 7'h7F;
            else a = 7'($urandom_range(126, 9));
            d = 16'($urandom);
            r = $urandom_range(7);
            nb = (r == 0) ? $urandom_range(23, 1) : (r == 1) ? $urandom_range(30, 25) : 24;
            if (nb < 24) begin
                c0 = wr_cnt;
                frame(rw, a, d, nb, -1, rd);
                chk("rnd_abort_pulses", wr_cnt - c0, 0);
            end else if (rw) begin
                do_read(a, rd);
            end else begin
                do_write(a, d, nb);
            end
        end

        quiet = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
